// File: rtl/fetch_redirect_unit.sv
// ---------------------------------------------------------------------------
// fetch_redirect_unit
//
// Instruction-fetch stage. Holds the PC, issues one word request at a time to
// instruction memory and buffers returned instructions (with their PC) in a
// small FIFO for decode. A taken branch/jump from EX redirects the PC, flushes
// the FIFO and marks any in-flight request as wrong-path so that its response
// is discarded.
//
// Ports:
//   clk, rst_n                 core clock, asynchronous active-low reset
//   br_valid, br_res, br_target branch resolution from EX (redirect when both set)
//   imem_req_valid/ready/addr  fetch request channel (word aligned)
//   imem_rsp_valid/data        in-order fetch response
//   if_valid/ready, if_instr, if_pc  instruction stream to decode (FIFO head)
//   redirect_cnt, drop_cnt     (FETCH_REDIRECT_CNT_EN only) saturating counters
//                              of redirects and of discarded responses
//
// Optional feature macro: FETCH_REDIRECT_CNT_EN
// ---------------------------------------------------------------------------
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        br_valid,
  input  logic        br_res,
  input  logic [31:0] br_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [31:0] redirect_cnt,
  output logic [31:0] drop_cnt
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc, w_pc_nxt;
  logic [PW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic [31:0]     r_buf_instr [FIFO_DEPTH];
  logic [31:0]     r_buf_pc    [FIFO_DEPTH];

  logic w_redirect, w_req_hs, w_push, w_pop, w_drop;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign w_redirect = br_valid & br_res;

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign imem_req_valid = rst_n & (r_state == S_REQ) & (r_count < DEPTH_C);
  assign imem_req_addr  = r_pc;
  assign w_req_hs       = imem_req_valid & imem_req_ready;

  assign if_valid = (r_count != '0);
  assign if_instr = r_buf_instr[r_rptr];
  assign if_pc    = r_buf_pc[r_rptr];

  // A redirect flushes the FIFO, so a pop in the same cycle is meaningless.
  assign w_pop  = if_valid & if_ready & ~w_redirect;
  assign w_push = (r_state == S_WAIT) & imem_rsp_valid & ~w_redirect;
  assign w_drop = imem_rsp_valid &
                  (((r_state == S_WAIT) & w_redirect) | (r_state == S_DROP));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_hs) w_state_nxt = w_redirect ? S_DROP : S_WAIT;
      S_WAIT:  if (imem_rsp_valid) w_state_nxt = S_REQ;
               else if (w_redirect) w_state_nxt = S_DROP;
      S_DROP:  if (imem_rsp_valid) w_state_nxt = S_REQ;
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_redirect)    w_pc_nxt = {br_target[31:2], 2'b00};
    else if (w_req_hs) w_pc_nxt = r_pc + 32'd4;
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_redirect)            w_count_nxt = '0;
    else if (w_push && !w_pop) w_count_nxt = r_count + CW'(1);
    else if (w_pop && !w_push) w_count_nxt = r_count - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_count <= w_count_nxt;
      if (w_redirect) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PW'(1);
        if (w_pop)  r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // The PC stored with each entry is pc-4 because pc already advanced at the
  // request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_buf_instr[i] <= '0;
        r_buf_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_buf_instr[r_wptr] <= imem_rsp_data;
      r_buf_pc[r_wptr]    <= r_pc - 32'd4;
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] r_redirect_cnt, r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_redirect) r_redirect_cnt <= sat_inc(r_redirect_cnt);
      if (w_drop)     r_drop_cnt     <= sat_inc(r_drop_cnt);
    end
  end

  assign redirect_cnt = r_redirect_cnt;
  assign drop_cnt     = r_drop_cnt;
`endif

  // A free slot is reserved when a request is issued, so a push can never
  // land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (r_count < DEPTH_C));

  // With no request outstanding there is nothing for a response to answer.
  a_no_rsp_in_req: assert property (@(posedge clk) disable iff (!rst_n)
    !((r_state == S_REQ) && imem_rsp_valid));

endmodule

// File: tb/tb_fetch_redirect_unit.sv
module tb_fetch_redirect_unit;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        br_valid, br_res;
  logic [31:0] br_target;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt, drop_cnt;
`endif

  fetch_redirect_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .br_valid(br_valid), .br_res(br_res), .br_target(br_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef FETCH_REDIRECT_CNT_EN
    , .redirect_cnt(redirect_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC, one outstanding request (none/live/stale), FIFO queue.
  logic [31:0] m_pc;
  int          m_out;          // 0 none, 1 live (correct path), 2 stale
  logic [31:0] m_live_addr;
  logic [63:0] m_q[$];         // {pc, instr}
  logic [31:0] m_rcnt, m_dcnt;

  // Memory environment
  bit          mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          rdy_pct = 100, lat_min = 1, lat_max = 1;
  bit          redir_on_rsp = 0;
  logic [31:0] redir_tgt = 32'h0;

  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_1234;
  endfunction

  function automatic logic [31:0] sat(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit exp_req_valid();
    return (m_out == 0) && (m_q.size() < DEPTH);
  endfunction

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hBAD0_BAD0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("req_valid", 32'(imem_req_valid), 32'(exp_req_valid()));
    check("req_addr", imem_req_addr, m_pc);
    check("if_valid", 32'(if_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("if_instr", if_instr, m_q[0][31:0]);
      check("if_pc", if_pc, m_q[0][63:32]);
    end
`ifdef FETCH_REDIRECT_CNT_EN
    check("redirect_cnt", redirect_cnt, m_rcnt);
    check("drop_cnt", drop_cnt, m_dcnt);
`endif
  endtask

  task automatic model_update();
    bit          redir, hs, pop, push;
    logic [31:0] pc_now;
    redir  = br_valid && br_res;
    hs     = exp_req_valid() && imem_req_ready;
    pop    = (m_q.size() != 0) && if_ready && !redir;
    push   = 0;
    pc_now = m_pc;
    if (redir) m_rcnt = sat(m_rcnt);
    if (m_out != 0 && imem_rsp_valid) begin
      if (m_out == 1 && !redir) push = 1;
      else m_dcnt = sat(m_dcnt);
      m_out = 0;
    end else if (m_out == 0 && hs) begin
      m_out       = redir ? 2 : 1;
      m_live_addr = pc_now;
    end else if (m_out == 1 && redir) begin
      m_out = 2;
    end
    if (redir) m_q.delete();
    else begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back({m_live_addr, imem_rsp_data});
    end
    if (m_q.size() > DEPTH) begin
      errors++;
      $display("FAIL model_depth: got %0d expected <= %0d", m_q.size(), DEPTH);
    end
    if (redir)   m_pc = {br_target[31:2], 2'b00};
    else if (hs) m_pc = pc_now + 32'd4;
    if (mem_busy && imem_rsp_valid) mem_busy = 0;
    if (hs) begin
      mem_busy = 1;
      mem_cnt  = $urandom_range(lat_max, lat_min);
      mem_addr = pc_now;
    end
  endtask

  task automatic step(input bit bv, input bit br, input logic [31:0] tgt, input bit ifr);
    @(negedge clk);
    compare();
    br_valid       = bv;
    br_res         = br;
    br_target      = tgt;
    if_ready       = ifr;
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(mem_addr);
        if (redir_on_rsp) begin
          br_valid     = 1'b1;
          br_res       = 1'b1;
          br_target    = redir_tgt;
          redir_on_rsp = 0;
        end
      end
    end
    if (imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (if_valid && if_ready && !(br_valid && br_res)) pop_log.push_back(if_pc);
    @(posedge clk);
    model_update();
  endtask

  task automatic run(input int n, input bit ifr);
    repeat (n) step(1'b0, 1'b0, 32'h0, ifr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    br_valid = 0; br_res = 0; br_target = 0;
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0; if_ready = 0;
    m_pc = RPC; m_out = 0; m_q.delete(); m_rcnt = 0; m_dcnt = 0;
    mem_busy = 0; mem_cnt = 0; redir_on_rsp = 0;
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_req_addr", imem_req_addr, RPC);
    rst_n = 1'b1;
    req_log.delete();
    pop_log.delete();
  endtask

  task automatic wait_model(input int q_size, input bit ifr, input string name);
    int n;
    n = 0;
    while (!(m_q.size() == q_size && m_out == 1) && n < 60) begin
      step(1'b0, 1'b0, 32'h0, ifr);
      n++;
    end
    if (n >= 60) begin
      errors++;
      $display("FAIL %s: condition not reached within 60 cycles", name);
    end
  endtask

  initial begin
    int n;
    bit bv, br, ifr;
    logic [31:0] tgt;

    // 1: straight-line fetch
    rdy_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    run(12, 1'b1);
    check("t1_req0", at(req_log, 0), 32'h100);
    check("t1_req1", at(req_log, 1), 32'h104);
    check("t1_req2", at(req_log, 2), 32'h108);
    check("t1_pop0", at(pop_log, 0), 32'h100);
    check("t1_pop1", at(pop_log, 1), 32'h104);
    check("t1_pop2", at(pop_log, 2), 32'h108);
    check("t1_pop_rate", 32'(pop_log.size()), 32'd5);

    // 2: back-pressure fills the FIFO
    do_reset();
    run(10, 1'b0);
    #1;
    check("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_full_if_pc", if_pc, 32'h100);
    req_log.delete();
    run(10, 1'b1);
    check("t2_pop0", at(pop_log, 0), 32'h100);
    check("t2_pop1", at(pop_log, 1), 32'h104);
    check("t2_pop2", at(pop_log, 2), 32'h108);
    check("t2_resume", at(req_log, 0), 32'h108);

    // 3: redirect while waiting, with one entry buffered
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_model(1, 1'b0, "t3_setup");
    step(1'b1, 1'b1, 32'h2002, 1'b0);
    #1;
    check("t3_flushed", 32'(if_valid), 32'd0);
    req_log.delete();
    pop_log.delete();
    run(14, 1'b1);
    check("t3_target_req", at(req_log, 0), 32'h2000);
    check("t3_first_pop", at(pop_log, 0), 32'h2000);
`ifdef FETCH_REDIRECT_CNT_EN
    check("t3_drop_cnt", drop_cnt, 32'd1);
    check("t3_redirect_cnt", redirect_cnt, 32'd1);
`endif

    // 4: redirect coincident with a response
    lat_min = 2; lat_max = 2;
    do_reset();
    run(3, 1'b1);
    redir_tgt = 32'h3000;
    redir_on_rsp = 1;
    n = 0;
    while (redir_on_rsp && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    if (redir_on_rsp) begin
      errors++;
      $display("FAIL t4_setup: response never arrived");
    end
    #1;
    check("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check("t4_req_addr", imem_req_addr, 32'h3000);
    check("t4_if_valid", 32'(if_valid), 32'd0);

    // 5: not-taken branch is a no-op
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (12) step(1'b1, 1'b0, 32'hDEAD_0000, 1'b1);
    check("t5_pop0", at(pop_log, 0), 32'h100);
    check("t5_pop1", at(pop_log, 1), 32'h104);
    check("t5_pop2", at(pop_log, 2), 32'h108);

    // PC wrap, redirect in the same cycle as a request handshake
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
    run(8, 1'b1);
    check("wrap_req0", at(req_log, 0), 32'h100);
    check("wrap_req1", at(req_log, 1), 32'hFFFF_FFFC);
    check("wrap_req2", at(req_log, 2), 32'h0);
    check("wrap_pop0", at(pop_log, 0), 32'hFFFF_FFFC);

    // 6: asynchronous reset in WAIT with one entry buffered
    lat_min = 3; lat_max = 3;
    do_reset();
    wait_model(1, 1'b0, "t6_setup");
    #1;
    check("t6_pre_if_valid", 32'(if_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_if_valid", 32'(if_valid), 32'd0);
    check("t6_async_req_valid", 32'(imem_req_valid), 32'd0);
    check("t6_async_if_pc", if_pc, 32'd0);
    check("t6_async_if_instr", if_instr, 32'd0);
    lat_min = 1; lat_max = 1;
    do_reset();
    run(6, 1'b1);
    check("t6_restart", at(req_log, 0), RPC);

    // Randomized traffic
    rdy_pct = 70; lat_min = 1; lat_max = 3;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bv  = ($urandom_range(9) == 0);
      br  = $urandom_range(1);
      tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      ifr = ($urandom_range(3) != 0);
      if ($urandom_range(49) == 0) begin
        redir_tgt    = $urandom;
        redir_on_rsp = 1;
      end
      step(bv, br, tgt, ifr);
    end
    @(negedge clk);
    compare();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
